muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Sequences a shared iterative radix-2 divider for DIV/DIVU/REM/REMU instructions issued from the Execute stage.
- Holds the pipeline by raising a stall request while the divide is in progress. The hazard logic ORs this request into stallF/stallD and into an Execute-stage hold.
- Presents one result, with a one-cycle done strobe, back to the Execute-stage result mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 4.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- startE  input  1  a valid divide/remainder op is in Execute, already qualified by the caller against flushE
- opE  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- srcaE  input  WIDTH  dividend, forwarded value
- srcbE  input  WIDTH  divisor, forwarded value
- killE  input  1  abort the in-flight op (trap/redirect)
- mdstallE  output  1  stall request to the hazard unit
- mddoneE  output  1  result valid this cycle
- mdresultE  output  WIDTH  quotient or remainder selected by the latched op

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (synchronous): state=IDLE, counter=0, internal operand/result registers=0. Outputs during and after reset: mdstallE=0, mddoneE=0, mdresultE=0. Reset mid-CALC abandons the op with no done strobe.
- IDLE:
  - mdstallE = startE, combinational, so the accept cycle is already stalled.
  - On startE: latch opE, the sign flags and the absolute values for signed ops.
  - If srcbE==0, or a signed op with srcaE=100..0 and srcbE=all-ones: go to DONE with the special result preloaded. Otherwise go to CALC with counter=0.
- CALC:
  - mdstallE=1.
  - Each cycle: one shift-subtract step on {remainder, quotient}; counter++.
  - When counter==WIDTH-1, go to DONE on the next edge; exactly WIDTH CALC cycles.
- DONE:
  - mdstallE=0, mddoneE=1.
  - mdresultE = sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU).
  - Quotient is negated iff the operand signs differ. Remainder takes the sign of the dividend.
  - startE is ignored in DONE, since the same instruction is still in E. Always go to IDLE next.
- Latency:
  - Normal op accepted at cycle t: stall high in t..t+WIDTH, done at t+WIDTH+1.
  - Special case: stall high at t only, done at t+1.
- Back-to-back: a new startE in the IDLE cycle after DONE is accepted normally. There are no dead cycles beyond DONE→IDLE.
- Divide by zero:
  - Quotient = all-ones for both signed and unsigned.
  - Remainder = srcaE unchanged.
- Signed overflow (most-negative / -1): quotient = 100..0, remainder = 0.
- killE:
  - Highest priority after reset, in any state: next state IDLE, no done strobe.
  - mdstallE is forced 0 in the kill cycle.
- mdresultE holds its last value outside DONE. Consumers must qualify it with mddoneE.
- All arithmetic is unsigned on WIDTH+1-bit partial remainders. Sign handling is applied only at latch time and at output.

Decomposition:
- Shared package:
  - md_op_t encodings (DIV/DIVU/REM/REMU).
  - md_state_t (IDLE/CALC/DONE).
  - Constants for the special-case results.
- Sub-module div_step_core:
  - Owns the remainder/quotient shift registers and the subtract step.
  - Controlled by load/step enables from the FSM.
  - Reusable if a multiply sequencer is added later.

Test Plan:
- DIVU, a=100, b=7, startE held → mdstallE high for 33 cycles, mddoneE at cycle 33 with result 14; REMU same operands → 2.
- DIV, a=-7 (0xFFFFFFF9), b=2 → result 0xFFFFFFFD (-3); REM same → 0xFFFFFFFF (-1); DIV, a=7, b=-2 → 0xFFFFFFFD.
- Divide by zero, DIVU a=0x1234, b=0 → done at t+1, result 0xFFFFFFFF; REM a=0x1234, b=0 → 0x1234, one stall cycle only.
- Overflow, DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at t+1; REM → 0.
- killE asserted at CALC counter=10 → next cycle state IDLE, mdstallE=0, no mddoneE; a following DIVU 9/3 completes normally → 3.
- Reset asserted mid-CALC, then released → all outputs 0. Two back-to-back DIVU ops (20/4 then 21/5) give done strobes with results 5 then 4, separated by exactly 1 IDLE + 32 CALC cycles.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Shared op/state encodings and special-case result constants
//               for the Execute-stage divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    // Special-result constants are sized for the widest supported datapath
    // and sliced down by the user; WIDTH must not exceed c_MD_MAX_WIDTH.
    localparam int          c_MD_MAX_WIDTH = 64;
    localparam logic [63:0] c_MD_DIVZ_QUO  = '1;
    localparam logic [63:0] c_MD_OVF_REM   = '0;

    function automatic logic mdIsSigned(input md_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic mdIsRem(input md_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step_core.sv
`default_nettype none
// ============================================================================
// Module      : div_step_core
// Description : Unsigned restoring radix-2 shift-subtract datapath; one
//               quotient bit per step, loaded and stepped by a controller.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] loadQuo,
    input  logic [WIDTH-1:0] loadRem,
    input  logic [WIDTH-1:0] loadDiv,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_fits;

    // The dividend is shifted out of the quotient register MSB-first while
    // quotient bits shift in from the bottom.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[WIDTH-1:0] - r_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (load) begin
            r_quo <= loadQuo;
            r_rem <= loadRem;
            r_div <= loadDiv;
        end else if (step) begin
            r_rem <= w_fits ? w_sub : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Execute-stage DIV/DIVU/REM/REMU sequencer around a shared
//               iterative divider; stalls the pipe and strobes one result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             killE,
    output logic             mdstallE,
    output logic             mddoneE,
    output logic [WIDTH-1:0] mdresultE
);

    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNTW-1:0]  c_LAST_CNT = CNTW'(WIDTH - 1);

    md_state_t        r_state;
    md_op_t           r_op;
    logic             r_negQ;
    logic             r_negR;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_held;

    logic             w_signedOp;
    logic             w_negA;
    logic             w_negB;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic             w_divZero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_loadQuo;
    logic [WIDTH-1:0] w_loadRem;
    logic             w_accept;
    logic             w_step;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_result;

    assign w_signedOp = mdIsSigned(md_op_t'(opE));
    assign w_negA     = w_signedOp && srcaE[WIDTH-1];
    assign w_negB     = w_signedOp && srcbE[WIDTH-1];
    assign w_absA     = w_negA ? (~srcaE + WIDTH'(1)) : srcaE;
    assign w_absB     = w_negB ? (~srcbE + WIDTH'(1)) : srcbE;

    assign w_divZero  = (srcbE == '0);
    assign w_ovf      = w_signedOp && (srcaE == c_MOST_NEG) && (srcbE == '1);
    assign w_special  = w_divZero || w_ovf;

    // Special cases preload the final answer so DONE needs no correction.
    always_comb begin
        w_loadQuo = w_absA;
        w_loadRem = '0;
        if (w_divZero) begin
            w_loadQuo = c_MD_DIVZ_QUO[WIDTH-1:0];
            w_loadRem = srcaE;
        end else if (w_ovf) begin
            w_loadQuo = c_MOST_NEG;
            w_loadRem = c_MD_OVF_REM[WIDTH-1:0];
        end
    end

    assign w_accept = (r_state == ST_IDLE) && startE && !killE;
    assign w_step   = (r_state == ST_CALC) && !killE;

    div_step_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (w_accept),
        .step      (w_step),
        .loadQuo   (w_loadQuo),
        .loadRem   (w_loadRem),
        .loadDiv   (w_absB),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_comb begin
        w_result = r_negQ ? (~w_quo + WIDTH'(1)) : w_quo;
        if (mdIsRem(r_op)) begin
            w_result = r_negR ? (~w_rem + WIDTH'(1)) : w_rem;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_DIV;
            r_negQ  <= 1'b0;
            r_negR  <= 1'b0;
            r_cnt   <= '0;
            r_held  <= '0;
        end else if (killE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (startE) begin
                        r_op    <= md_op_t'(opE);
                        r_negQ  <= !w_special && (w_negA ^ w_negB);
                        r_negR  <= !w_special && w_negA;
                        r_cnt   <= '0;
                        r_state <= w_special ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CNTW'(1);
                    if (r_cnt == c_LAST_CNT) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The issuing instruction is still in E; never re-accept here.
                    r_held  <= w_result;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Accept-cycle stall is combinational so the issuing instruction holds in E.
    assign mdstallE  = !reset && !killE &&
                       (((r_state == ST_IDLE) && startE) || (r_state == ST_CALC));
    assign mddoneE   = !reset && !killE && (r_state == ST_DONE);
    assign mdresultE = reset ? '0 : ((r_state == ST_DONE) ? w_result : r_held);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer with a
//               result scoreboard and stall/done timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         startE;
    logic [1:0]   opE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         killE;
    logic         mdstallE;
    logic         mddoneE;
    logic [W-1:0] mdresultE;

    int           compared   = 0;
    int           mismatched = 0;
    int           cycleNo    = 0;
    logic [W-1:0] sb[$];

    muldiv_sequencer #(
        .WIDTH (W),
        .CNTW  (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .startE    (startE),
        .opE       (opE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .killE     (killE),
        .mdstallE  (mdstallE),
        .mddoneE   (mddoneE),
        .mdresultE (mdresultE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleNo++;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 of the IDLE cycle after DONE.
    task automatic divOp(input string tag, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expRes, input int expStall,
                         output int doneAt);
        int stall   = 0;
        int cyc     = 0;
        int doneCyc = -1;
        logic [W-1:0] exp;
        doneAt = -1;
        sb.push_back(expRes);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        while (doneCyc < 0 && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) check({tag, " acceptStall"}, W'(mdstallE), 1);
            if (mddoneE === 1'b1) begin
                doneCyc = cyc;
                doneAt  = cycleNo;
                check({tag, " stallAtDone"}, W'(mdstallE), 0);
                exp = sb.pop_front();
                check({tag, " result"}, mdresultE, exp);
            end else if (mdstallE === 1'b1) begin
                stall++;
            end
            nextCycle();
            cyc++;
        end
        startE = 1'b0;
        check({tag, " doneCycle"}, W'(doneCyc), W'(expStall));
        check({tag, " stallCycles"}, W'(stall), W'(expStall));
    endtask

    initial begin
        int d1;
        int d2;
        int spurious;
        reset  = 1'b1;
        startE = 1'b0;
        killE  = 1'b0;
        opE    = 2'b00;
        srcaE  = '0;
        srcbE  = '0;

        nextCycle();
        nextCycle();
        @(negedge clk);
        check("rstStall",  W'(mdstallE), 0);
        check("rstDone",   W'(mddoneE), 0);
        check("rstResult", mdresultE, 0);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        check("postRstStall",  W'(mdstallE), 0);
        check("postRstDone",   W'(mddoneE), 0);
        check("postRstResult", mdresultE, 0);
        nextCycle();

        divOp("divu100_7", 2'b01, 32'd100, 32'd7, 32'd14, W + 1, d1);
        @(negedge clk);
        check("holdResult", mdresultE, 32'd14);
        check("holdDone",   W'(mddoneE), 0);
        check("holdStall",  W'(mdstallE), 0);
        nextCycle();
        divOp("remu100_7",  2'b11, 32'd100, 32'd7, 32'd2, W + 1, d1);
        divOp("divNeg7_2",  2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, W + 1, d1);
        divOp("remNeg7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, W + 1, d1);
        divOp("div7_neg2",  2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, W + 1, d1);
        divOp("rem7_neg2",  2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, W + 1, d1);
        divOp("divuByZero", 2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, d1);
        divOp("remByZero",  2'b10, 32'h1234, 32'd0, 32'h1234, 1, d1);
        divOp("divByZero",  2'b00, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 1, d1);
        divOp("divOvf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, d1);
        divOp("remOvf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, d1);
        divOp("divuNoOvf",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, W + 1, d1);

        // Kill while the counter reads 10 (accept + 11 cycles).
        startE = 1'b1;
        opE    = 2'b01;
        srcaE  = 32'hFFFF_FFFF;
        srcbE  = 32'd3;
        nextCycle();
        startE = 1'b0;
        repeat (10) nextCycle();
        killE = 1'b1;
        @(negedge clk);
        check("killStall", W'(mdstallE), 0);
        check("killDone",  W'(mddoneE), 0);
        nextCycle();
        killE = 1'b0;
        @(negedge clk);
        check("afterKillStall", W'(mdstallE), 0);
        check("afterKillDone",  W'(mddoneE), 0);
        spurious = 0;
        repeat (40) begin
            nextCycle();
            @(negedge clk);
            if (mddoneE !== 1'b0 || mdstallE !== 1'b0) spurious++;
        end
        check("killNoActivity", W'(spurious), 0);
        nextCycle();
        divOp("divu9_3", 2'b01, 32'd9, 32'd3, 32'd3, W + 1, d1);

        // Reset in the middle of CALC.
        startE = 1'b1;
        opE    = 2'b01;
        srcaE  = 32'd50;
        srcbE  = 32'd3;
        nextCycle();
        startE = 1'b0;
        repeat (5) nextCycle();
        reset = 1'b1;
        @(negedge clk);
        check("midRstStall",  W'(mdstallE), 0);
        check("midRstDone",   W'(mddoneE), 0);
        check("midRstResult", mdresultE, 0);
        nextCycle();
        reset = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (mddoneE !== 1'b0 || mdstallE !== 1'b0 || mdresultE !== '0) spurious++;
            nextCycle();
        end
        check("postMidRstQuiet", W'(spurious), 0);

        divOp("b2b20_4", 2'b01, 32'd20, 32'd4, 32'd5, W + 1, d1);
        divOp("b2b21_5", 2'b01, 32'd21, 32'd5, 32'd4, W + 1, d2);
        check("b2bSpacing", W'(d2 - d1), W'(W + 2));

        check("scoreboardEmpty", W'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
